// File: rtl/spill_fifo_pkg.sv
// Shared helpers for the flushable spill FIFO.
// Also provides the codebase flop sensitivity macro if the build has not
// already defined it. Reset is synchronous, so only the clock edge appears.
`ifndef GROVF_RDMA_CLK_RSTN
`define GROVF_RDMA_CLK_RSTN(clk, rstn) posedge clk
`endif

package spill_fifo_pkg;

  localparam int DropCntWidth = 16;

  // Bits needed to count 0..depth occupied entries.
  function automatic int usage_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/spill_fifo_ptr.sv
// One wrapping FIFO pointer (0..Depth-1), also correct for non-power-of-two Depth.
`ifndef GROVF_RDMA_CLK_RSTN
`define GROVF_RDMA_CLK_RSTN(clk, rstn) posedge clk
`endif

module spill_fifo_ptr #(
  parameter int Depth = 4,
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            inc,
  input  logic            clr,
  output logic [PtrW-1:0] ptr
);

  // Advance on inc, wrap at Depth-1; reset and clear both return to slot 0.
  always_ff @(`GROVF_RDMA_CLK_RSTN(clk_i, rst_ni)) begin
    if (!rst_ni || clr) ptr <= '0;
    else if (inc)       ptr <= (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  end

endmodule

// File: rtl/spill_fifo_flushable.sv
// Flushable FIFO with registered ready/valid (no ready_i->ready_o or
// valid_i->valid_o combinational paths). Bypass=1 makes it a wire-through.
// Optional feature: define SPILL_FIFO_DROP_CNT_EN to add drop_cnt_o, a
// saturating count of entries discarded by flush.
// Simulation checks are removed when COMMON_CELLS_ASSERTS_OFF is defined.
`ifndef GROVF_RDMA_CLK_RSTN
`define GROVF_RDMA_CLK_RSTN(clk, rstn) posedge clk
`endif

module spill_fifo_flushable
  import spill_fifo_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int Depth     = 4,
  parameter bit Bypass    = 1'b0,
  localparam int UsageW   = usage_width(Depth)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 flush_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [DataWidth-1:0] data_o,
  output logic [UsageW-1:0]    usage_o
`ifdef SPILL_FIFO_DROP_CNT_EN
  ,
  output logic [DropCntWidth-1:0] drop_cnt_o
`endif
);

  if (Bypass) begin : g_bypass
    // Transparent: handshake and payload pass straight through, flush ignored.
    logic unused_bypass;
    assign unused_bypass = ^{clk_i, rst_ni, flush_i};
    assign valid_o = valid_i;
    assign ready_o = ready_i;
    assign data_o  = data_i;
    assign usage_o = '0;
`ifdef SPILL_FIFO_DROP_CNT_EN
    assign drop_cnt_o = '0;
`endif
  end else begin : g_fifo
    localparam int PtrW = $clog2(Depth);

    logic [DataWidth-1:0] mem [Depth];
    logic [PtrW-1:0]      rptr, wptr;
    logic [UsageW-1:0]    usage;
    logic                 push, pop;

    // Handshakes derive from the occupancy register only.
    assign ready_o = (usage != UsageW'(Depth));
    assign valid_o = (usage != '0);
    assign push    = valid_i && ready_o && !flush_i;
    assign pop     = valid_o && ready_i && !flush_i;
    assign data_o  = mem[rptr];
    assign usage_o = usage;

    spill_fifo_ptr #(.Depth(Depth)) u_wptr (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .inc   (push),
      .clr   (flush_i),
      .ptr   (wptr)
    );

    spill_fifo_ptr #(.Depth(Depth)) u_rptr (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .inc   (pop),
      .clr   (flush_i),
      .ptr   (rptr)
    );

    // Storage: zeroed on reset, written at the write pointer on push.
    always_ff @(`GROVF_RDMA_CLK_RSTN(clk_i, rst_ni)) begin
      if (!rst_ni) begin
        for (int i = 0; i < Depth; i++) mem[i] <= '0;
      end else if (push) begin
        mem[wptr] <= data_i;
      end
    end

    // Occupancy: flush empties; simultaneous push and pop leave it unchanged.
    always_ff @(`GROVF_RDMA_CLK_RSTN(clk_i, rst_ni)) begin
      if (!rst_ni || flush_i)  usage <= '0;
      else if (push && !pop)   usage <= usage + UsageW'(1);
      else if (pop && !push)   usage <= usage - UsageW'(1);
    end

`ifdef SPILL_FIFO_DROP_CNT_EN
    localparam int SumW = DropCntWidth + 1;
    logic [DropCntWidth-1:0] drop_cnt;
    logic [SumW-1:0]         drop_sum;

    // A flush loses every stored entry plus the word offered that cycle.
    assign drop_sum   = {1'b0, drop_cnt} + SumW'(usage) + SumW'(valid_i);
    assign drop_cnt_o = drop_cnt;

    // Saturating drop counter, updated only on flush.
    always_ff @(`GROVF_RDMA_CLK_RSTN(clk_i, rst_ni)) begin
      if (!rst_ni)      drop_cnt <= '0;
      else if (flush_i) drop_cnt <= drop_sum[DropCntWidth] ? '1 : drop_sum[DropCntWidth-1:0];
    end
`endif

`ifndef COMMON_CELLS_ASSERTS_OFF
    // Simulation-only sanity checks on the handshake.
    always @(posedge clk_i) begin
      if (rst_ni) begin
        if (flush_i && valid_i)
          $warning("spill_fifo_flushable: valid_i word dropped by flush_i");
        if (push && usage == UsageW'(Depth))
          $error("spill_fifo_flushable: push while full");
        if (pop && usage == '0)
          $error("spill_fifo_flushable: pop while empty");
      end
    end
`endif
  end

endmodule
